// File: rtl/vc_dest_arbiter.sv
// Pops the VC0/VC1 FIFOs with weighted VC0 priority and routes each word by its
// destination bit into the D0/D1 FIFOs through a pop -> pend -> push pipeline.
module vc_dest_arbiter #(
  parameter int unsigned data_width = 6,
  parameter int unsigned dest_bit   = 4,
  parameter int unsigned vc0_weight = 4,
  parameter int unsigned cnt_width  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [data_width-1:0] vc0_data,
  input  logic [data_width-1:0] vc1_data,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic                  d0_almost_full,
  input  logic                  d1_almost_full,
  input  logic                  d0_full,
  input  logic                  d1_full,
  output logic                  vc0_pop,
  output logic                  vc1_pop,
  output logic                  d0_push,
  output logic                  d1_push,
  output logic [data_width-1:0] d0_data,
  output logic [data_width-1:0] d1_data,
  output logic [cnt_width-1:0]  d0_count,
  output logic [cnt_width-1:0]  d1_count,
  output logic                  overflow_err,
  output logic                  idle
);

  localparam int unsigned burst_width = 4;
  localparam logic [burst_width-1:0] burst_max = burst_width'(vc0_weight);

  logic                   flush;
  logic                   pop_ok;
  logic                   pend_valid;
  logic                   pend_src;
  logic [burst_width-1:0] burst_cnt;
  logic [data_width-1:0]  word;

  assign flush = reset | ~init;

  // Destination is unknown at pop time, so both D FIFOs must have room.
  assign pop_ok  = ~flush & ~d0_almost_full & ~d1_almost_full & ~d0_full & ~d1_full;
  assign vc0_pop = pop_ok & ~vc0_empty & (vc1_empty | (burst_cnt < burst_max));
  assign vc1_pop = pop_ok & ~vc1_empty & ~vc0_pop;

  assign word = pend_src ? vc1_data : vc0_data;
  assign idle = ~pend_valid & ~d0_push & ~d1_push & vc0_empty & vc1_empty;

  // Consecutive VC0 grants while VC1 is waiting
  always_ff @(posedge clk) begin
    if (flush) begin
      burst_cnt <= '0;
    end else if (vc1_pop) begin
      burst_cnt <= '0;
    end else if (vc0_pop && !vc1_empty) begin
      if (burst_cnt != burst_max) burst_cnt <= burst_cnt + burst_width'(1);
    end else if (vc1_empty) begin
      burst_cnt <= '0;
    end
  end

  // Pend stage: remembers which VC will present data next cycle
  always_ff @(posedge clk) begin
    if (flush) begin
      pend_valid <= 1'b0;
      pend_src   <= 1'b0;
    end else begin
      pend_valid <= vc0_pop | vc1_pop;
      pend_src   <= vc1_pop;
    end
  end

  // Push stage: route by destination bit; unused data register holds
  always_ff @(posedge clk) begin
    if (flush) begin
      d0_push <= 1'b0;
      d1_push <= 1'b0;
      d0_data <= '0;
      d1_data <= '0;
    end else begin
      d0_push <= pend_valid & ~word[dest_bit];
      d1_push <= pend_valid & word[dest_bit];
      if (pend_valid && !word[dest_bit]) d0_data <= word;
      if (pend_valid && word[dest_bit])  d1_data <= word;
    end
  end

  // Forwarded-word counters and sticky overflow flag
  always_ff @(posedge clk) begin
    if (flush) begin
      d0_count     <= '0;
      d1_count     <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (d0_push) d0_count <= d0_count + cnt_width'(1);
      if (d1_push) d1_count <= d1_count + cnt_width'(1);
      if ((d0_push && d0_full) || (d1_push && d1_full)) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Randomized and directed bench for vc_dest_arbiter; a scoreboard of popped words
// is checked against the D-side pushes by an independent monitor process.
module tb_vc_dest_arbiter;

  localparam int unsigned DW = 6;
  localparam int unsigned DB = 4;
  localparam int          WT = 4;
  localparam int unsigned CW = 8;

  typedef struct {
    logic [DW-1:0] w;
    int            cyc;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init = 1'b0;
  logic [DW-1:0] vc0_data = '0;
  logic [DW-1:0] vc1_data = '0;
  logic          vc0_empty = 1'b1;
  logic          vc1_empty = 1'b1;
  logic          d0_almost_full = 1'b0;
  logic          d1_almost_full = 1'b0;
  logic          d0_full = 1'b0;
  logic          d1_full = 1'b0;
  logic          vc0_pop, vc1_pop, d0_push, d1_push, overflow_err, idle;
  logic [DW-1:0] d0_data, d1_data;
  logic [CW-1:0] d0_count, d1_count;

  // Control values applied at the next falling edge
  logic n_reset = 1'b1, n_init = 1'b0;
  logic n_af0 = 1'b0, n_af1 = 1'b0, n_f0 = 1'b0, n_f1 = 1'b0;

  logic [DW-1:0] vc0_q[$];
  logic [DW-1:0] vc1_q[$];
  ent_t          sb[$];
  int            pop_log[$];
  bit            log_en = 1'b0;
  int            cyc = 0;
  int            run = 0;
  logic [DW-1:0] nxt0 = '0, nxt1 = '0;
  int            errors = 0, checks = 0;

  logic [CW-1:0] c0 = '0, c1 = '0;
  logic          ovf = 1'b0;
  logic [DW-1:0] last0 = '0, last1 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vc_dest_arbiter #(
    .data_width(DW), .dest_bit(DB), .vc0_weight(WT), .cnt_width(CW)
  ) dut (
    .clk(clk), .reset(reset), .init(init),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
    .d0_full(d0_full), .d1_full(d1_full),
    .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
    .d0_push(d0_push), .d1_push(d1_push),
    .d0_data(d0_data), .d1_data(d1_data),
    .d0_count(d0_count), .d1_count(d1_count),
    .overflow_err(overflow_err), .idle(idle)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One cycle: drive inputs at negedge, check grants, model the VC FIFOs
  task automatic tick();
    bit pok, e0, e1;
    @(negedge clk);
    reset = n_reset;  init = n_init;
    d0_almost_full = n_af0;  d1_almost_full = n_af1;
    d0_full = n_f0;  d1_full = n_f1;
    vc0_data = nxt0;  vc1_data = nxt1;
    vc0_empty = (vc0_q.size() == 0);
    vc1_empty = (vc1_q.size() == 0);
    #1;
    pok = init && !reset && !d0_almost_full && !d1_almost_full && !d0_full && !d1_full;
    e0  = pok && !vc0_empty && (vc1_empty || run < WT);
    e1  = pok && !vc1_empty && !e0;
    chk("vc0_pop", vc0_pop, e0);
    chk("vc1_pop", vc1_pop, e1);
    // run = VC0 grants since VC1 was last served or seen empty
    if (reset || !init)            run = 0;
    else if (e1)                   run = 0;
    else if (e0 && !vc1_empty)     run = (run < WT) ? run + 1 : WT;
    else if (vc1_empty)            run = 0;
    nxt0 = '0;
    nxt1 = '0;
    if (vc0_pop === 1'b1 && vc0_q.size() > 0) begin
      nxt0 = vc0_q.pop_front();
      sb.push_back('{nxt0, cyc});
      if (log_en) pop_log.push_back(0);
    end
    if (vc1_pop === 1'b1 && vc1_q.size() > 0) begin
      nxt1 = vc1_q.pop_front();
      sb.push_back('{nxt1, cyc});
      if (log_en) pop_log.push_back(1);
    end
    #2;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((vc0_q.size() + vc1_q.size() + sb.size()) != 0 && n < maxc) begin
      tick();
      n++;
    end
    chk("drain_done", n < maxc, 1);
  endtask

  // Monitor: each popped word must appear on its destination 2 cycles after the pop
  always begin : monitor
    bit   x0, x1, xidle;
    ent_t e;
    @(negedge clk);
    #2;
    x0 = 1'b0;
    x1 = 1'b0;
    xidle = vc0_empty && vc1_empty && (sb.size() == 0);
    if (sb.size() > 0 && sb[0].cyc + 2 == cyc) begin
      e = sb.pop_front();
      if (e.w[DB]) begin x1 = 1'b1; last1 = e.w; end
      else         begin x0 = 1'b1; last0 = e.w; end
    end
    chk("d0_push", d0_push, x0);
    chk("d1_push", d1_push, x1);
    chk("d0_data", d0_data, last0);
    chk("d1_data", d1_data, last1);
    chk("d0_count", d0_count, c0);
    chk("d1_count", d1_count, c1);
    chk("overflow_err", overflow_err, ovf);
    chk("idle", idle, xidle);
    if (x0) c0 = c0 + 1'b1;
    if (x1) c1 = c1 + 1'b1;
    ovf = ovf | (x0 & d0_full) | (x1 & d1_full);
    if (reset || !init) begin
      c0 = '0;  c1 = '0;  ovf = 1'b0;
      last0 = '0;  last1 = '0;
      sb.delete();
    end
  end

  initial begin
    // Reset with both VCs loaded, then the weighted grant pattern
    for (int i = 0; i < 10; i++) begin
      vc0_q.push_back(DW'($urandom));
      vc1_q.push_back(DW'($urandom));
    end
    n_reset = 1'b1;  n_init = 1'b1;
    tick();  tick();
    chk("reset_vc0_pop", vc0_pop, 0);
    chk("reset_push", d0_push | d1_push, 0);
    log_en = 1'b1;
    n_reset = 1'b0;
    tick();
    chk("first_pop", vc0_pop, 1);
    drain(100);
    log_en = 1'b0;
    begin
      automatic int n0 = 10;
      automatic int n1 = 10;
      automatic int exp_log[$];
      while (n0 > 0) begin
        for (int k = 0; k < WT && n0 > 0; k++) begin exp_log.push_back(0); n0--; end
        if (n0 > 0 && n1 > 0) begin exp_log.push_back(1); n1--; end
      end
      while (n1 > 0) begin exp_log.push_back(1); n1--; end
      chk("fair_len", pop_log.size(), exp_log.size());
      for (int i = 0; i < exp_log.size() && i < pop_log.size(); i++)
        chk("fair_seq", pop_log[i], exp_log[i]);
    end

    // Routing by destination bit
    n_init = 1'b0;  tick();
    n_init = 1'b1;  tick();
    chk("flush_d0_count", d0_count, 0);
    chk("flush_d1_count", d1_count, 0);
    vc0_q.push_back(6'h05);
    vc0_q.push_back(6'h15);
    drain(20);
    tick();
    chk("route_d0_data", d0_data, 6'h05);
    chk("route_d1_data", d1_data, 6'h15);
    chk("route_d0_count", d0_count, 1);
    chk("route_d1_count", d1_count, 1);

    // Backpressure mid-stream
    for (int i = 0; i < 20; i++) vc0_q.push_back(DW'($urandom));
    tick();  tick();  tick();
    n_af1 = 1'b1;
    begin
      automatic int tot = 0;
      automatic int late = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (d0_push || d1_push) begin
          tot++;
          if (i >= 2) late++;
        end
      end
      chk("bp_pushes_le2", tot <= 2, 1);
      chk("bp_late_push", late, 0);
    end
    n_af1 = 1'b0;
    drain(60);

    // Overflow on a D0-bound word, sticky until flush
    vc0_q.push_back(6'h0A);
    tick();  tick();
    n_f0 = 1'b1;  tick();
    n_f0 = 1'b0;  tick();
    chk("ovf_set", overflow_err, 1);
    tick();  tick();
    chk("ovf_sticky", overflow_err, 1);

    // Flush with a word in the pend stage
    vc0_q.push_back(6'h03);
    tick();
    n_init = 1'b0;  tick();
    n_init = 1'b1;  tick();  tick();  tick();
    chk("flush_ovf", overflow_err, 0);
    chk("flush_count", d0_count, 0);
    chk("flush_no_push", d0_push, 0);
    chk("flush_idle", idle, 1);

    // Counter wrap after 256 D0 words
    for (int i = 0; i < 256; i++) begin
      automatic logic [DW-1:0] w = DW'($urandom);
      w[DB] = 1'b0;
      vc0_q.push_back(w);
    end
    drain(300);
    tick();
    chk("wrap_d0_count", d0_count, 0);
    chk("wrap_d1_count", d1_count, 0);
    chk("wrap_idle", idle, 1);

    // Random traffic, flags, flushes and resets
    repeat (800) begin
      if ($urandom_range(0, 2) == 0 && vc0_q.size() < 6) vc0_q.push_back(DW'($urandom));
      if ($urandom_range(0, 2) == 0 && vc1_q.size() < 6) vc1_q.push_back(DW'($urandom));
      n_af0   = ($urandom_range(0, 9) == 0);
      n_af1   = ($urandom_range(0, 9) == 0);
      n_f0    = ($urandom_range(0, 39) == 0);
      n_f1    = ($urandom_range(0, 39) == 0);
      n_init  = ($urandom_range(0, 59) != 0);
      n_reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    n_af0 = 1'b0;  n_af1 = 1'b0;  n_f0 = 1'b0;  n_f1 = 1'b0;
    n_init = 1'b1;  n_reset = 1'b0;
    drain(200);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
